stream_mux_rr: RTL and testbench

//  - Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshake.
//  - Successor to the combinational 2:1 byte select: supports arbitrary width and channel count.
//  - Two select modes: fixed (external SEL) and round-robin arbitration.
//  - Sits between datapath sources and a single shared sink (ALU operand bus, UART TX, display driver).

---
 rtl/stream_mux_rr_pkg.sv | 18 +
 rtl/stream_mux_rr_arbiter.sv | 62 ++++++
 rtl/stream_mux_rr.sv | 187 ++++++++++++++++++
 tb/tb_stream_mux_rr.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_rr_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_rr_pkg
// Shared definitions for the round-robin stream multiplexer:
//   MODE_FIXED / MODE_RR : encodings of the MODE input
//   lock_state_e         : packet-lock FSM state encodings (ST_IDLE, ST_LOCK),
//                          used only when STREAM_MUX_PKT_LOCK_EN is defined
// -----------------------------------------------------------------------------
package stream_mux_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } lock_state_e;

endpackage : stream_mux_rr_pkg

// File: rtl/stream_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational grant logic for stream_mux_rr.
// Ports:
//   REQ       in  N   per-channel request (IN_VALID)
//   PTR       in  SW  round-robin start position
//   MODE      in  1   MODE_FIXED: grant SEL if requesting; MODE_RR: scan from PTR
//   SEL       in  SW  fixed-mode channel index (values >= N never grant)
//   GNT_VALID out 1   a channel is granted
//   GNT_IDX   out SW  granted channel index (0 when GNT_VALID=0)
// -----------------------------------------------------------------------------
module rr_arbiter
   import stream_mux_rr_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  REQ,
   input  logic [SW-1:0] PTR,
   input  logic          MODE,
   input  logic [SW-1:0] SEL,
   output logic          GNT_VALID,
   output logic [SW-1:0] GNT_IDX
);

   logic          gnt_valid_s;
   logic [SW-1:0] gnt_idx_s;

   // Grant selection: fixed index or first requester at/after PTR, wrapping mod N
   always_comb begin
      int          cand_v;
      logic [SW-1:0] idx_v;
      gnt_valid_s = 1'b0;
      gnt_idx_s   = '0;
      cand_v      = 0;
      idx_v       = '0;
      if (MODE == MODE_RR) begin
         for (int i = 0; i < N; i++) begin
            // N need not be a power of two, so wrap with a modulo rather than overflow
            cand_v = (int'(PTR) + i) % N;
            idx_v  = SW'(cand_v);
            if (!gnt_valid_s && REQ[idx_v]) begin
               gnt_valid_s = 1'b1;
               gnt_idx_s   = idx_v;
            end else begin
               gnt_valid_s = gnt_valid_s;
            end
         end
      end else begin
         if ((int'(SEL) < N) && REQ[SEL]) begin
            gnt_valid_s = 1'b1;
            gnt_idx_s   = SEL;
         end else begin
            gnt_valid_s = 1'b0;
         end
      end
   end

   assign GNT_VALID = gnt_valid_s;
   assign GNT_IDX   = gnt_idx_s;

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N-channel, W-bit registered stream multiplexer with valid/ready handshake,
// fixed-select or round-robin arbitration, single-entry output register with
// full throughput (load while draining).
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN -- adds IN_LAST/OUT_LAST and a
// lock FSM that holds the grant on one channel until its LAST beat.
// Ports:
//   CLK, RST (async, active high)
//   MODE, SEL                     grant mode and fixed-mode channel index
//   IN_DATA[N*W], IN_VALID[N]     channel k data at [k*W +: W]
//   IN_READY[N]                   one-hot or zero
//   OUT_DATA, OUT_CH, OUT_VALID   registered output word and its source channel
//   OUT_READY                     sink accept
//   IN_LAST[N], OUT_LAST          only with STREAM_MUX_PKT_LOCK_EN
// -----------------------------------------------------------------------------
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           MODE,
   input  logic [SW-1:0]  SEL,
   input  logic [N*W-1:0] IN_DATA,
   input  logic [N-1:0]   IN_VALID,
   output logic [N-1:0]   IN_READY,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [N-1:0]   IN_LAST,
   output logic           OUT_LAST,
`endif
   output logic [W-1:0]   OUT_DATA,
   output logic [SW-1:0]  OUT_CH,
   output logic           OUT_VALID,
   input  logic           OUT_READY
);

   logic [W-1:0]  ch_data_s [N];
   logic [SW-1:0] ptr_r;
   logic [SW-1:0] ptr_nxt_s;
   logic          arb_valid_s;
   logic [SW-1:0] arb_idx_s;
   logic          gnt_valid_s;
   logic [SW-1:0] gnt_idx_s;
   logic          ld_s;
   logic          xfer_s;
   logic          adv_ptr_s;
   logic [N-1:0]  in_ready_s;
   logic [W-1:0]  out_data_r;
   logic [SW-1:0] out_ch_r;
   logic          out_valid_r;

   rr_arbiter #(.N(N), .SW(SW)) u_arb (
      .REQ       (IN_VALID),
      .PTR       (ptr_r),
      .MODE      (MODE),
      .SEL       (SEL),
      .GNT_VALID (arb_valid_s),
      .GNT_IDX   (arb_idx_s)
   );

   // Unpack the flat input bus into per-channel words
   always_comb begin
      for (int k = 0; k < N; k++) begin
         ch_data_s[k] = IN_DATA[k*W +: W];
      end
   end

   assign ld_s = !out_valid_r || OUT_READY;

`ifdef STREAM_MUX_PKT_LOCK_EN
   lock_state_e   state_r;
   logic [SW-1:0] lock_ch_r;
   logic          out_last_r;

   // Grant: locked channel overrides the arbiter for the rest of its packet
   always_comb begin
      if (state_r == ST_LOCK) begin
         gnt_valid_s = IN_VALID[lock_ch_r];
         gnt_idx_s   = lock_ch_r;
      end else begin
         gnt_valid_s = arb_valid_s;
         gnt_idx_s   = arb_idx_s;
      end
   end

   // Pointer moves only once a packet finishes
   assign adv_ptr_s = xfer_s && IN_LAST[gnt_idx_s];

   // Packet lock FSM
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r   <= ST_IDLE;
         lock_ch_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (xfer_s && !IN_LAST[gnt_idx_s]) begin
                  state_r   <= ST_LOCK;
                  lock_ch_r <= gnt_idx_s;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_LOCK: begin
               if (xfer_s && IN_LAST[gnt_idx_s]) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_LOCK;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               lock_ch_r <= '0;
            end
         endcase
      end
   end

   // LAST flag travels with the registered word
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_last_r <= 1'b0;
      end else if (xfer_s) begin
         out_last_r <= IN_LAST[gnt_idx_s];
      end else begin
         out_last_r <= out_last_r;
      end
   end

   assign OUT_LAST = out_last_r;
`else
   assign gnt_valid_s = arb_valid_s;
   assign gnt_idx_s   = arb_idx_s;
   assign adv_ptr_s   = xfer_s;
`endif

   // RST gating keeps upstream from seeing a handshake while the register is cleared
   assign xfer_s = gnt_valid_s && ld_s && !RST;

   assign ptr_nxt_s = (gnt_idx_s == SW'(N-1)) ? '0 : (gnt_idx_s + SW'(1));

   // One-hot ready toward the granted channel only
   always_comb begin
      in_ready_s = '0;
      if (xfer_s) begin
         in_ready_s[gnt_idx_s] = 1'b1;
      end else begin
         in_ready_s = '0;
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_data_r  <= '0;
         out_ch_r    <= '0;
         out_valid_r <= 1'b0;
         ptr_r       <= '0;
      end else begin
         if (xfer_s) begin
            // Covers the load-while-draining case: the new word replaces the old one
            out_data_r  <= ch_data_s[gnt_idx_s];
            out_ch_r    <= gnt_idx_s;
            out_valid_r <= 1'b1;
         end else if (out_valid_r && OUT_READY) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         if (adv_ptr_s) begin
            ptr_r <= ptr_nxt_s;
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   assign IN_READY  = in_ready_s;
   assign OUT_DATA  = out_data_r;
   assign OUT_CH    = out_ch_r;
   assign OUT_VALID = out_valid_r;

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
// Directed bench for stream_mux_rr: a 4-channel instance for the main tests and
// a 3-channel instance for the non-power-of-two cases. Inputs change 1 ns after
// the rising edge; outputs are checked before the next rising edge.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic        mode3;
   logic [1:0]  sel3;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;
   logic        out_ready3;

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic [3:0]  in_last;
   logic        out_last;
   logic [2:0]  in_last3;
   logic        out_last3;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   logic [7:0] exp_data [4];

   always #5 clk = ~clk;

   stream_mux_rr #(.W(8), .N(4)) dut (
      .CLK       (clk),
      .RST       (rst),
      .MODE      (mode),
      .SEL       (sel),
      .IN_DATA   (in_data),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .IN_LAST   (in_last),
      .OUT_LAST  (out_last),
`endif
      .OUT_DATA  (out_data),
      .OUT_CH    (out_ch),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready)
   );

   stream_mux_rr #(.W(8), .N(3)) dut3 (
      .CLK       (clk),
      .RST       (rst),
      .MODE      (mode3),
      .SEL       (sel3),
      .IN_DATA   (in_data3),
      .IN_VALID  (in_valid3),
      .IN_READY  (in_ready3),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .IN_LAST   (in_last3),
      .OUT_LAST  (out_last3),
`endif
      .OUT_DATA  (out_data3),
      .OUT_CH    (out_ch3),
      .OUT_VALID (out_valid3),
      .OUT_READY (out_ready3)
   );

   task automatic test_reset();
      rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== 8'h00) begin n_fails++; $display("FAIL reset_data: got %h expected 00", out_data); end
      n_checks++; if (out_ch !== 2'd0) begin n_fails++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
      n_checks++; if (in_ready !== 4'b0000) begin n_fails++; $display("FAIL reset_ready: got %b expected 0000", in_ready); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 4'b0001) begin n_fails++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin n_fails++; $display("FAIL reset_first_word: got valid=%b ch=%0d expected valid=1 ch=0", out_valid, out_ch); end
      // mid-cycle reset pulse must clear outputs and ready without a clock edge
      #2; rst = 1'b1; #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_async_valid: got %b expected 0", out_valid); end
      n_checks++; if (in_ready !== 4'b0000) begin n_fails++; $display("FAIL reset_async_ready: got %b expected 0000", in_ready); end
      @(posedge clk); #1;
      rst = 1'b0; #1;
      n_checks++; if (in_ready !== 4'b0001) begin n_fails++; $display("FAIL reset_ptr_zero: got %b expected 0001", in_ready); end
      in_valid = 4'b0000;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_idle: got %b expected 0", out_valid); end
   endtask

   task automatic test_fixed();
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 4'b0100) begin n_fails++; $display("FAIL fixed_ready: got %b expected 0100", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fails++; $display("FAIL fixed_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_data !== 8'hA5) begin n_fails++; $display("FAIL fixed_data: got %h expected a5", out_data); end
      n_checks++; if (out_ch !== 2'd2) begin n_fails++; $display("FAIL fixed_ch: got %0d expected 2", out_ch); end
      // selected channel not valid: no grant even though others are valid
      sel = 2'd1; in_valid = 4'b1101;
      #1;
      n_checks++; if (in_ready !== 4'b0000) begin n_fails++; $display("FAIL fixed_sel_idle: got %b expected 0000", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL fixed_drain_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== 8'hA5 || out_ch !== 2'd2) begin n_fails++; $display("FAIL fixed_drain_hold: got data=%h ch=%0d expected data=a5 ch=2", out_data, out_ch); end
      in_valid = 4'b0000;
   endtask

   task automatic test_round_robin();
      rst = 1'b1; #2; rst = 1'b0;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== exp_data[i % 4]) begin
            n_fails++;
            $display("FAIL rr_seq[%0d]: got valid=%b ch=%0d data=%h expected valid=1 ch=%0d data=%h",
                     i, out_valid, out_ch, out_data, i % 4, exp_data[i % 4]);
         end
      end
   endtask

   task automatic test_backpressure();
      // continues from round-robin: ch0 held, pointer at 1
      out_ready = 1'b0;
      #1;
      n_checks++; if (in_ready !== 4'b0000) begin n_fails++; $display("FAIL bp_ready_now: got %b expected 0000", in_ready); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hC0 || in_ready !== 4'b0000) begin
            n_fails++;
            $display("FAIL bp_hold[%0d]: got valid=%b ch=%0d data=%h ready=%b expected valid=1 ch=0 data=c0 ready=0000",
                     i, out_valid, out_ch, out_data, in_ready);
         end
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 4'b0010) begin n_fails++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_ch !== 2'd1 || out_data !== 8'hC1) begin n_fails++; $display("FAIL bp_resume: got ch=%0d data=%h expected ch=1 data=c1", out_ch, out_data); end
      in_valid = 4'b0000;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_sparse();
      rst = 1'b1; #2; rst = 1'b0;
      // one fixed-mode transfer from ch0 leaves the pointer at 1
      mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
      @(posedge clk); #1;
      mode = 1'b1; in_valid = 4'b1001;
      #1;
      n_checks++; if (in_ready !== 4'b1000) begin n_fails++; $display("FAIL sparse_ready3: got %b expected 1000", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_ch !== 2'd3 || out_data !== 8'hC3) begin n_fails++; $display("FAIL sparse_word3: got ch=%0d data=%h expected ch=3 data=c3", out_ch, out_data); end
      n_checks++; if (in_ready !== 4'b0001) begin n_fails++; $display("FAIL sparse_wrap_ready: got %b expected 0001", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_ch !== 2'd0 || out_data !== 8'hC0) begin n_fails++; $display("FAIL sparse_word0: got ch=%0d data=%h expected ch=0 data=c0", out_ch, out_data); end
      in_valid = 4'b0000;
      @(posedge clk); #1;
   endtask

   task automatic test_three_channels();
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
            n_fails++;
            $display("FAIL n3_sel_out_of_range[%0d]: got ready=%b valid=%b expected ready=000 valid=0", i, in_ready3, out_valid3);
         end
      end
      mode3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid3 !== 1'b1 || out_ch3 !== 2'(i % 3) || out_data3 !== 8'(8'h30 + i % 3)) begin
            n_fails++;
            $display("FAIL n3_rr_seq[%0d]: got valid=%b ch=%0d data=%h expected valid=1 ch=%0d data=%h",
                     i, out_valid3, out_ch3, out_data3, i % 3, 8'(8'h30 + i % 3));
         end
      end
      in_valid3 = 3'b000;
      @(posedge clk); #1;
   endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
   task automatic test_pkt_lock();
      rst = 1'b1; #2; rst = 1'b0;
      mode = 1'b0; sel = 2'd1; in_valid = 4'b0111; in_last = 4'b0000; out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_ch !== 2'd1 || out_last !== 1'b0) begin n_fails++; $display("FAIL lock_beat1: got ch=%0d last=%b expected ch=1 last=0", out_ch, out_last); end
      // round-robin from pointer 0 would pick ch0; the lock must keep ch1
      mode = 1'b1; sel = 2'd0;
      @(posedge clk); #1;
      n_checks++; if (out_ch !== 2'd1 || out_last !== 1'b0) begin n_fails++; $display("FAIL lock_beat2: got ch=%0d last=%b expected ch=1 last=0", out_ch, out_last); end
      in_last = 4'b0010;
      @(posedge clk); #1;
      n_checks++; if (out_ch !== 2'd1 || out_last !== 1'b1) begin n_fails++; $display("FAIL lock_beat3: got ch=%0d last=%b expected ch=1 last=1", out_ch, out_last); end
      in_last = 4'b0000;
      @(posedge clk); #1;
      n_checks++; if (out_ch !== 2'd2) begin n_fails++; $display("FAIL lock_next: got ch=%0d expected 2", out_ch); end
      in_valid = 4'b0000;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      exp_data[0] = 8'hC0; exp_data[1] = 8'hC1; exp_data[2] = 8'hA5; exp_data[3] = 8'hC3;
      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_data = 32'hC3A5C1C0; in_valid = 4'b0000; out_ready = 1'b0;
      mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h323130; in_valid3 = 3'b000; out_ready3 = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      in_last = 4'b1111; in_last3 = 3'b111;
`endif
      test_reset();
      test_fixed();
      test_round_robin();
      test_backpressure();
      test_sparse();
      test_three_channels();
`ifdef STREAM_MUX_PKT_LOCK_EN
      test_pkt_lock();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_stream_mux_rr
